// File: rtl/fizz_buzz_if.sv
// fizz_buzz_if: output bundle of the FizzBuzz generator.
// The generator drives the count and the three classification flags
// through the master modport; any consumer samples them via the slave modport.
interface fizz_buzz_if #(
  parameter int CNT_W = 16
);
  logic             fizz;
  logic             buzz;
  logic             fizzbuzz;
  logic [CNT_W-1:0] count;

  // Generator side: produces count and flags.
  modport master (
    output fizz,
    output buzz,
    output fizzbuzz,
    output count
  );

  // Consumer side: samples count and flags on any edge.
  modport slave (
    input fizz,
    input buzz,
    input fizzbuzz,
    input count
  );
endinterface

// File: rtl/fizz_buzz.sv
// fizz_buzz: free-running FizzBuzz sequence generator.
// A counter advances every clock. Two residue registers track count modulo
// FIZZ_DIV and BUZZ_DIV incrementally, so no divider is needed. The flags are
// decoded combinationally from the registered residues, so they always
// describe the value currently on count.
module fizz_buzz #(
  parameter int CNT_W    = 16,
  parameter int FIZZ_DIV = 3,
  parameter int BUZZ_DIV = 5
) (
  input  logic         clk,
  input  logic         resetn,   // active-high asynchronous reset despite the name
  fizz_buzz_if.master  fb
);

  // Residue register widths: wide enough to hold 0..DIV-1 (at least one bit).
  localparam int R3_W = (FIZZ_DIV > 2) ? $clog2(FIZZ_DIV) : 1;
  localparam int R5_W = (BUZZ_DIV > 2) ? $clog2(BUZZ_DIV) : 1;

  // Last value before each residue wraps back to 0.
  localparam logic [R3_W-1:0]  R3_LAST  = R3_W'(FIZZ_DIV - 1);
  localparam logic [R5_W-1:0]  R5_LAST  = R5_W'(BUZZ_DIV - 1);
  // Last counter value before the counter wraps back to 0.
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [R3_W-1:0]  r3_reg;
  logic [R3_W-1:0]  r3_next;
  logic [R5_W-1:0]  r5_reg;
  logic [R5_W-1:0]  r5_next;
  logic             r3_zero;
  logic             r5_zero;

  // Next-state: advance count and both residues; on counter wrap all three
  // restart together so the residues stay consistent with count = 0 even when
  // 2^CNT_W is not a multiple of either divisor.
  always_comb begin
    count_next = count_reg + 1'b1;
    r3_next    = (r3_reg == R3_LAST) ? '0 : r3_reg + 1'b1;
    r5_next    = (r5_reg == R5_LAST) ? '0 : r5_reg + 1'b1;
    if (count_reg == CNT_LAST) begin
      count_next = '0;
      r3_next    = '0;
      r5_next    = '0;
    end
  end

  // State registers: cleared immediately by reset, otherwise advance every edge.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      count_reg <= '0;
      r3_reg    <= '0;
      r5_reg    <= '0;
    end else begin
      count_reg <= count_next;
      r3_reg    <= r3_next;
      r5_reg    <= r5_next;
    end
  end

  // Output decode from registered state only; the three flags are mutually
  // exclusive by construction.
  always_comb begin
    r3_zero     = (r3_reg == '0);
    r5_zero     = (r5_reg == '0);
    fb.fizzbuzz = r3_zero && r5_zero;
    fb.fizz     = r3_zero && !r5_zero;
    fb.buzz     = !r3_zero && r5_zero;
    fb.count    = count_reg;
  end

endmodule

// File: tb/tb_fizz_buzz.sv
// tb_fizz_buzz: self-checking bench for fizz_buzz.
// Two instances run side by side: a default 16-bit counter and a 5-bit counter
// that wraps every 32 cycles. Both share clock and reset and are compared each
// cycle against an arithmetic reference (n mod 2^W, then mod 3 / mod 5).
module tb_fizz_buzz;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  fizz_buzz_if #(.CNT_W(16)) bus_big ();
  fizz_buzz_if #(.CNT_W(5))  bus_small ();

  fizz_buzz #(.CNT_W(16), .FIZZ_DIV(3), .BUZZ_DIV(5)) dut_big (
    .clk    (clk),
    .resetn (resetn),
    .fb     (bus_big)
  );

  fizz_buzz #(.CNT_W(5), .FIZZ_DIV(3), .BUZZ_DIV(5)) dut_small (
    .clk    (clk),
    .resetn (resetn),
    .fb     (bus_small)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned ref_n  = 0;   // edges seen since last reset

  // Expected {fizz,buzz,fizzbuzz} for the first eight values after release.
  logic [2:0] seq_flags [8] = '{3'b001, 3'b000, 3'b000, 3'b100,
                                3'b000, 3'b010, 3'b100, 3'b000};

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t n=%0d)", tag, got, exp, $time, ref_n);
    end
  endtask

  // Compare one instance against the arithmetic reference for width w.
  task automatic check_dut(input string name, input int w, input logic [31:0] cnt,
                           input logic f, input logic b, input logic fzb);
    int unsigned v;
    v = ref_n % (32'd1 << w);
    check_value({name, "_count"},    cnt, v);
    check_value({name, "_fizz"},     {31'd0, f},   {31'd0, (v % 3 == 0) && (v % 5 != 0)});
    check_value({name, "_buzz"},     {31'd0, b},   {31'd0, (v % 3 != 0) && (v % 5 == 0)});
    check_value({name, "_fizzbuzz"}, {31'd0, fzb}, {31'd0, (v % 15 == 0)});
    check_value({name, "_onehot"},   {31'd0, ($countones({f, b, fzb}) <= 1)}, 32'd1);
  endtask

  task automatic check_all();
    check_dut("big", 16, {16'd0, bus_big.count},
              bus_big.fizz, bus_big.buzz, bus_big.fizzbuzz);
    check_dut("small", 5, {27'd0, bus_small.count},
              bus_small.fizz, bus_small.buzz, bus_small.fizzbuzz);
    // Named milestones with constant expectations.
    if (ref_n == 9)  check_value("n9_fizz",      {31'd0, bus_big.fizz},     32'd1);
    if (ref_n == 10) check_value("n10_buzz",     {31'd0, bus_big.buzz},     32'd1);
    if (ref_n == 15) check_value("n15_fizzbuzz", {31'd0, bus_big.fizzbuzz}, 32'd1);
    if (ref_n == 30) check_value("n30_fizzbuzz", {31'd0, bus_big.fizzbuzz}, 32'd1);
    if (ref_n == 62) check_value("w30_fizzbuzz", {31'd0, bus_small.fizzbuzz}, 32'd1);
    if (ref_n == 63) check_value("w31_noflags",
                                 {29'd0, bus_small.fizz, bus_small.buzz, bus_small.fizzbuzz}, 32'd0);
    if (ref_n == 64) check_value("w0_fizzbuzz",
                                 {27'd0, bus_small.count, bus_small.fizzbuzz}, 32'd1);
    if (ref_n == 65) check_value("w1_noflags",
                                 {29'd0, bus_small.fizz, bus_small.buzz, bus_small.fizzbuzz}, 32'd0);
    if (ref_n == 67) check_value("w3_fizz",      {31'd0, bus_small.fizz},   32'd1);
  endtask

  // One clock: advance the reference on the rising edge, sample on the falling edge.
  task automatic step();
    @(posedge clk);
    if (resetn) ref_n = 0;
    else        ref_n++;
    @(negedge clk);
    check_all();
  endtask

  // Assert reset between edges, check it acts without a clock, hold, release.
  task automatic async_reset(input int hold);
    #($urandom_range(1, 3));
    resetn = 1'b1;
    ref_n  = 0;
    #1;
    check_value("async_count",    {16'd0, bus_big.count},    32'd0);
    check_value("async_fizzbuzz", {31'd0, bus_big.fizzbuzz}, 32'd1);
    check_all();
    repeat (hold) step();
    resetn = 1'b0;
  endtask

  initial begin
    // Reset with no clock edge yet, then hold across two edges.
    #1 resetn = 1'b1;
    #1 check_all();
    repeat (2) step();

    // Release on a falling edge; first sample is 0, then one per edge.
    resetn = 1'b0;
    check_all();
    for (int i = 0; i < 8; i++) begin
      if (i != 0) step();
      check_value("seq_count", {16'd0, bus_big.count}, i);
      check_value("seq_flags", {29'd0, bus_big.fizz, bus_big.buzz, bus_big.fizzbuzz},
                  {29'd0, seq_flags[i]});
    end

    // Run to 12, reset mid-cycle, resume 0..3.
    repeat (5) step();
    check_value("pre_reset_count", {16'd0, bus_big.count}, 32'd12);
    async_reset(2);
    check_all();
    repeat (3) step();
    check_value("resume_fizz", {31'd0, bus_big.fizz}, 32'd1);

    // Randomised segment with sporadic mid-cycle resets of random length.
    repeat (3000) begin
      step();
      if ($urandom_range(0, 199) == 0) async_reset($urandom_range(1, 3));
    end

    // Uninterrupted run through a full 16-bit wrap.
    repeat (65536 + 100) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fizz_buzz.md
# fizz_buzz

Free-running FizzBuzz sequence generator. An internal counter starts at 0 after reset and advances by one every clock. Three one-hot-or-zero flags classify the current count: divisible by 3 only, by 5 only, or by both. It is a self-contained stimulus/demo block with no input handshake; downstream logic samples the flags and count on any clock edge.

## Interface
Parameters:
- CNT_W, 16, width of the count register and output; must be ≥ 4.
- FIZZ_DIV, 3, fizz divisor; must be ≥ 2.
- BUZZ_DIV, 5, buzz divisor; must be ≥ 2 and ≠ FIZZ_DIV.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- resetn  input  1  reset, asynchronous and active-high. Despite the codebase name, the block is in reset while resetn = 1.
- fizz  output  1  count divisible by FIZZ_DIV and not by BUZZ_DIV.
- buzz  output  1  count divisible by BUZZ_DIV and not by FIZZ_DIV.
- fizzbuzz  output  1  count divisible by both FIZZ_DIV and BUZZ_DIV.
- count  output  CNT_W  current counter value, unsigned.

## Operation
- State registers:
  - count (CNT_W bits).
  - r3, the residue of count mod FIZZ_DIV, in the range 0..FIZZ_DIV-1.
  - r5, the residue of count mod BUZZ_DIV, in the range 0..BUZZ_DIV-1.
- No divider or modulo operator is used. Residues are maintained incrementally:
  - r3 wraps from FIZZ_DIV-1 to 0.
  - r5 wraps from BUZZ_DIV-1 to 0.
- Output decode is combinational from registered state only. No input-to-output paths.
  - fizzbuzz = (r3==0) && (r5==0)
  - fizz = (r3==0) && (r5!=0)
  - buzz = (r3!=0) && (r5==0)
- fizz, buzz and fizzbuzz are mutually exclusive; at most one is 1 in any cycle.
- Counter wrap: when count = 2^CNT_W-1, the next edge sets count, r3 and r5 all to 0. The flags always describe the value currently on count, including across the wrap.
- There is no enable and no stall; the counter advances every non-reset cycle.

## Timing
- Reset, while resetn = 1:
  - count, r3 and r5 clear to 0 immediately, with no clock needed.
  - Outputs during reset: count = 0, fizzbuzz = 1, fizz = 0, buzz = 0.
- Reset release:
  - Deassertion is taken on a rising edge. Value 0 is held until the first rising edge where resetn is sampled 0.
  - Each such edge then increments count by 1.
- Latency: the flags are valid in the same cycle as the count value they describe (zero-cycle decode after the register).
- Mid-run reset: an asynchronous assertion between edges forces count = 0 and fizzbuzz = 1 within the same cycle. The sequence restarts from 0 after release.
- Deassertion must meet recovery/removal timing relative to clk. A synchronizer is outside this block.

## Test plan
- Reset hold: assert resetn = 1 for 2 edges -> count = 0, fizzbuzz = 1, fizz = 0, buzz = 0 throughout.
- Release and run 8 cycles, sampled on each edge -> (count, fizz, buzz, fizzbuzz) equals:
  - (0,0,0,1)
  - (1,0,0,0)
  - (2,0,0,0)
  - (3,1,0,0)
  - (4,0,0,0)
  - (5,0,1,0)
  - (6,1,0,0)
  - (7,0,0,0)
- Run to count = 15 -> fizzbuzz = 1; count = 9 -> fizz = 1; count = 10 -> buzz = 1; count = 30 -> fizzbuzz = 1.
- Wrap with CNT_W = 5: count 30 -> fizzbuzz, 31 -> no flags, 0 -> fizzbuzz, 1 -> no flags, 3 -> fizz.
- Asynchronous reset asserted mid-cycle at count = 12 -> count = 0 and fizzbuzz = 1 before the next edge. After release the sequence resumes 0, 1, 2, 3 (fizz).
- Run 2^16 + 100 cycles with default parameters, comparing against a reference model (count % 3, count % 5) -> all flags match and at most one flag is high every cycle.
